// File: rtl/vfd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vfd_pkg
// Brief   : Shared state encoding and datapath defaults for the V/f sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package vfd_pkg;

    localparam int C_FREQ_W   = 16;
    localparam int C_VF_BOOST = 16;
    localparam int C_VF_SLOPE = 128;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCEL    = 3'd1,
        ST_RUN      = 3'd2,
        ST_DECEL    = 3'd3,
        ST_STOPPING = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vf_amplitude_calc.sv
`default_nettype none
// ============================================================================
// Module  : vf_amplitude_calc
// Brief   : Combinational V/f law: boost + (freq * slope) >> 8, saturated to 8 bits.
// Revision: 1.0 - initial release
// ============================================================================
module vf_amplitude_calc
    import vfd_pkg::*;
#(
    parameter int FREQ_W   = C_FREQ_W,
    parameter int VF_BOOST = C_VF_BOOST,
    parameter int VF_SLOPE = C_VF_SLOPE
) (
    input  logic [FREQ_W-1:0] i_freq,
    output logic [7:0]        o_amplitude
);

    localparam logic [FREQ_W+7:0] c_slope = (FREQ_W+8)'(VF_SLOPE);
    localparam logic [FREQ_W:0]   c_boost = (FREQ_W+1)'(VF_BOOST);
    localparam logic [FREQ_W:0]   c_sat   = (FREQ_W+1)'(255);

    logic [FREQ_W+7:0] w_prod;
    logic [FREQ_W:0]   w_sum;

    // Slope is Q0.8, so the integer part of the product is the upper FREQ_W bits.
    assign w_prod      = {8'd0, i_freq} * c_slope;
    assign w_sum       = c_boost + {1'b0, w_prod[FREQ_W+7:8]};
    assign o_amplitude = (w_sum > c_sat) ? 8'hFF : w_sum[7:0];

endmodule
`default_nettype wire

// File: rtl/vf_ramp_controller.sv
`default_nettype none
// ============================================================================
// Module  : vf_ramp_controller
// Brief   : V/f sequencer: slew-limited frequency ramp, start/stop/e-stop FSM.
// Revision: 1.0 - initial release
// ============================================================================
module vf_ramp_controller
    import vfd_pkg::*;
#(
    parameter int FREQ_W    = C_FREQ_W,
    parameter int RAMP_DIV  = 1000,
    parameter int FREQ_STEP = 1,
    parameter int F_MIN     = 20,
    parameter int F_MAX     = 'hFFFF,
    parameter int VF_BOOST  = C_VF_BOOST,
    parameter int VF_SLOPE  = C_VF_SLOPE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              estop,
    input  logic [FREQ_W-1:0] freq_cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [FREQ_W-1:0] freq_out,
    output logic [7:0]        amplitude,
    output logic              running,
    output logic              at_speed,
    output logic [2:0]        state
);

    localparam int                  c_presc_w    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(RAMP_DIV - 1);
    localparam logic [FREQ_W-1:0]    c_f_min      = FREQ_W'(F_MIN);
    localparam logic [FREQ_W-1:0]    c_f_max      = FREQ_W'(F_MAX);
    localparam logic [FREQ_W-1:0]    c_step       = FREQ_W'(FREQ_STEP);

    state_t                r_state;
    logic [FREQ_W-1:0]     r_target;
    logic [FREQ_W-1:0]     r_freq;
    logic [7:0]            r_amp;
    logic [c_presc_w-1:0]  r_presc;

    logic                  w_accept;
    logic                  w_step;
    logic [c_presc_w-1:0]  w_presc_inc;
    logic [FREQ_W-1:0]     w_cmd_clamped;
    logic [FREQ_W:0]       w_up_sum;
    logic [FREQ_W-1:0]     w_up;
    logic [FREQ_W-1:0]     w_dn;
    logic [FREQ_W-1:0]     w_stop_dn;
    logic [7:0]            w_amp;

    assign cmd_ready = (r_state == ST_IDLE) || (r_state == ST_ACCEL) ||
                       (r_state == ST_RUN)  || (r_state == ST_DECEL);
    assign running   = (r_state == ST_ACCEL) || (r_state == ST_RUN) ||
                       (r_state == ST_DECEL) || (r_state == ST_STOPPING);
    assign at_speed  = (r_state == ST_RUN);
    assign state     = r_state;
    assign freq_out  = r_freq;
    assign amplitude = r_amp;

    assign w_accept      = cmd_valid && cmd_ready;
    assign w_cmd_clamped = (freq_cmd < c_f_min) ? c_f_min :
                           (freq_cmd > c_f_max) ? c_f_max : freq_cmd;

    assign w_step      = (r_presc == c_presc_last);
    assign w_presc_inc = r_presc + c_presc_w'(1);

    // Step arithmetic is clamped against the goal before it can wrap either way.
    assign w_up_sum  = {1'b0, r_freq} + {1'b0, c_step};
    assign w_up      = (w_up_sum >= {1'b0, r_target}) ? r_target : w_up_sum[FREQ_W-1:0];
    assign w_dn      = ((r_freq - r_target) <= c_step) ? r_target : (r_freq - c_step);
    assign w_stop_dn = ((r_freq - c_f_min) <= c_step) ? c_f_min : (r_freq - c_step);

    vf_amplitude_calc #(
        .FREQ_W   (FREQ_W),
        .VF_BOOST (VF_BOOST),
        .VF_SLOPE (VF_SLOPE)
    ) u_amp_calc (
        .i_freq      (r_freq),
        .o_amplitude (w_amp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_target <= c_f_min;
            r_freq   <= '0;
            r_amp    <= '0;
            r_presc  <= '0;
        end else begin
            if (w_accept)
                r_target <= w_cmd_clamped;
            r_amp   <= w_amp;
            r_presc <= '0;
            if (estop) begin
                r_state <= ST_HALT;
                r_freq  <= '0;
                r_amp   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (enable) begin
                            r_state <= ST_ACCEL;
                            r_freq  <= c_f_min;
                        end else begin
                            r_freq <= '0;
                            r_amp  <= '0;
                        end
                    end
                    ST_ACCEL: begin
                        if (!enable)
                            r_state <= ST_STOPPING;
                        else if (r_target < r_freq)
                            r_state <= ST_DECEL;
                        else if (r_target == r_freq)
                            r_state <= ST_RUN;
                        else if (w_step) begin
                            r_freq <= w_up;
                            if (w_up == r_target)
                                r_state <= ST_RUN;
                        end else
                            r_presc <= w_presc_inc;
                    end
                    ST_RUN: begin
                        if (!enable)
                            r_state <= ST_STOPPING;
                        else if (r_target > r_freq)
                            r_state <= ST_ACCEL;
                        else if (r_target < r_freq)
                            r_state <= ST_DECEL;
                    end
                    ST_DECEL: begin
                        if (!enable)
                            r_state <= ST_STOPPING;
                        else if (r_target > r_freq)
                            r_state <= ST_ACCEL;
                        else if (r_target == r_freq)
                            r_state <= ST_RUN;
                        else if (w_step) begin
                            r_freq <= w_dn;
                            if (w_dn == r_target)
                                r_state <= ST_RUN;
                        end else
                            r_presc <= w_presc_inc;
                    end
                    ST_STOPPING: begin
                        // Enable is deliberately ignored: a stop always runs to IDLE.
                        if (w_step) begin
                            if (r_freq <= c_f_min) begin
                                r_state <= ST_IDLE;
                                r_freq  <= '0;
                                r_amp   <= '0;
                            end else
                                r_freq <= w_stop_dn;
                        end else
                            r_presc <= w_presc_inc;
                    end
                    ST_HALT: begin
                        r_freq <= '0;
                        r_amp  <= '0;
                        if (!enable)
                            r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_freq  <= '0;
                        r_amp   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vf_ramp_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_vf_ramp_controller
// Brief   : Self-checking bench for vf_ramp_controller (directed + random targets).
// Revision: 1.0 - initial release
// ============================================================================
module tb_vf_ramp_controller;

    localparam int P_FREQ_W = 16;
    localparam int P_DIV    = 4;
    localparam int P_STEP   = 10;
    localparam int P_FMIN   = 20;
    localparam int P_FMAX   = 500;
    localparam int P_BOOST  = 16;
    localparam int P_SLOPE  = 128;

    logic                clk;
    logic                rst;
    logic                enable;
    logic                estop;
    logic [P_FREQ_W-1:0] freq_cmd;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [P_FREQ_W-1:0] freq_out;
    logic [7:0]          amplitude;
    logic                running;
    logic                at_speed;
    logic [2:0]          state;

    int checks = 0;
    int errors = 0;

    vf_ramp_controller #(
        .FREQ_W    (P_FREQ_W),
        .RAMP_DIV  (P_DIV),
        .FREQ_STEP (P_STEP),
        .F_MIN     (P_FMIN),
        .F_MAX     (P_FMAX),
        .VF_BOOST  (P_BOOST),
        .VF_SLOPE  (P_SLOPE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .estop     (estop),
        .freq_cmd  (freq_cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .freq_out  (freq_out),
        .amplitude (amplitude),
        .running   (running),
        .at_speed  (at_speed),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int amp_of(input int f);
        int s;
        s = P_BOOST + (f * P_SLOPE) / 256;
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int clamp_cmd(input int c);
        return (c < P_FMIN) ? P_FMIN : (c > P_FMAX) ? P_FMAX : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one cycle after the DUT entered ACCEL/DECEL; follows the whole ramp.
    task automatic ramp_check(input string tag, input int from, input int to);
        int n, f, prev, dir;
        dir  = (to > from) ? 1 : 3;
        n    = ((to > from ? to - from : from - to) + P_STEP - 1) / P_STEP;
        prev = from;
        chk({tag, " entry state"}, state, dir);
        chk({tag, " entry freq"}, freq_out, from);
        for (int c = 1; c <= P_DIV * n; c++) begin
            tick(1);
            if (to > from) f = (from + P_STEP * (c / P_DIV) > to) ? to : from + P_STEP * (c / P_DIV);
            else           f = (from - P_STEP * (c / P_DIV) < to) ? to : from - P_STEP * (c / P_DIV);
            chk({tag, " freq"}, freq_out, f);
            chk({tag, " amp"}, amplitude, amp_of(prev));
            chk({tag, " state"}, state, (f == to) ? 2 : dir);
            prev = f;
        end
        chk({tag, " at_speed"}, at_speed, 1);
    endtask

    task automatic send_cmd(input int c);
        freq_cmd  = P_FREQ_W'(c);
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cur, tc, f, prev;
        rst = 1'b1; enable = 1'b0; estop = 1'b0; freq_cmd = '0; cmd_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);

        // Reset state
        chk("reset freq", freq_out, 0);
        chk("reset amp", amplitude, 0);
        chk("reset state", state, 0);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset running", running, 0);
        chk("reset at_speed", at_speed, 0);

        // Start to 100
        freq_cmd = 16'd100; cmd_valid = 1'b1; enable = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        chk("start amp", amplitude, amp_of(0));
        chk("start running", running, 1);
        ramp_check("accel100", P_FMIN, 100);
        tick(1);
        chk("amp at 100", amplitude, 66);

        // Decelerate to 65
        send_cmd(65);
        chk("decel pre state", state, 2);
        tick(1);
        ramp_check("decel65", 100, 65);
        tick(1);
        chk("amp at 65", amplitude, 48);

        // Clamp above F_MAX
        send_cmd(1000);
        tick(1);
        ramp_check("accel500", 65, 500);
        tick(1);
        chk("freq at 500", freq_out, 500);
        chk("amp saturated", amplitude, 255);

        // Down to 60, then stop with an ignored enable pulse and blocked command
        send_cmd(60);
        tick(1);
        ramp_check("decel60", 500, 60);
        enable = 1'b0;
        tick(1);
        chk("stop state", state, 4);
        chk("stop freq", freq_out, 60);
        chk("stop cmd_ready", cmd_ready, 0);
        chk("stop running", running, 1);
        chk("stop at_speed", at_speed, 0);
        prev = 60;
        freq_cmd = 16'd300; cmd_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            enable = (c == 6);
            tick(1);
            if (c < 20) begin
                f = (60 - P_STEP * (c / P_DIV) < P_FMIN) ? P_FMIN : 60 - P_STEP * (c / P_DIV);
                chk("stopping freq", freq_out, f);
                chk("stopping state", state, 4);
                chk("stopping cmd_ready", cmd_ready, 0);
                chk("stopping amp", amplitude, amp_of(prev));
                prev = f;
            end else begin
                chk("stopped freq", freq_out, 0);
                chk("stopped state", state, 0);
                chk("stopped amp", amplitude, 0);
            end
        end
        cmd_valid = 1'b0;
        tick(1);
        chk("idle hold state", state, 0);

        // Restart: target must still be 60, not the blocked 300
        enable = 1'b1;
        tick(1);
        ramp_check("restart60", P_FMIN, 60);

        // Estop during ACCEL
        send_cmd(200);
        tick(1);
        chk("estop pre state", state, 1);
        tick(5);
        estop = 1'b1;
        tick(1);
        chk("halt state", state, 5);
        chk("halt freq", freq_out, 0);
        chk("halt amp", amplitude, 0);
        chk("halt running", running, 0);
        chk("halt cmd_ready", cmd_ready, 0);
        estop = 1'b0;
        tick(3);
        chk("halt held with enable", state, 5);
        enable = 1'b0;
        tick(1);
        chk("halt exit state", state, 0);
        chk("halt exit cmd_ready", cmd_ready, 1);

        // Async reset mid-ACCEL
        enable = 1'b1;
        tick(7);
        chk("pre-rst state", state, 1);
        chk("pre-rst freq", freq_out, 30);
        #2 rst = 1'b1;
        #1;
        chk("async rst state", state, 0);
        chk("async rst freq", freq_out, 0);
        chk("async rst amp", amplitude, 0);
        chk("async rst running", running, 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("post-rst target=F_MIN state", state, 2);
        chk("post-rst freq", freq_out, P_FMIN);

        // Random targets from RUN
        cur = P_FMIN;
        for (int i = 0; i < 6; i++) begin
            tc = clamp_cmd(int'($urandom_range(0, 700)));
            send_cmd(tc == cur ? tc : int'($urandom_range(0, 700)) * 0 + tc);
            tick(1);
            if (tc == cur) begin
                chk("rand same state", state, 2);
                chk("rand same freq", freq_out, cur);
            end else begin
                ramp_check($sformatf("rand%0d", i), cur, tc);
                cur = tc;
            end
            tick(1);
            chk("rand final amp", amplitude, amp_of(cur));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
